sbox_array_pipe: RTL and testbench

//   LANES-wide pipelined AES byte-substitution unit (SubBytes / InvSubBytes) with valid/ready flow control.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/sbox_lane.sv | 30 +++
 rtl/sbox_array_pipe.sv | 103 ++++++++++
 tb/tb_sbox_array_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared AES constants, the S-box mode type and the GF(2^8) helper functions
//   used by the byte-substitution datapath.
//   Contents:
//     AES_POLY       reduction polynomial x^8+x^4+x^3+x+1 (low byte 0x1B)
//     SBOX_AFFINE_C  forward affine constant
//     INV_AFFINE_C   inverse affine constant
//     sbox_mode_e    SBOX_FWD / SBOX_INV
//     gf_mul, gf_inv, rotl8, affine_fwd, affine_inv
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY      = 8'h1B;
    localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
    localparam logic [7:0] INV_AFFINE_C  = 8'h05;

    typedef enum logic {
        SBOX_FWD = 1'b0,
        SBOX_INV = 1'b1
    } sbox_mode_e;

    // Shift-and-add multiply with reduction by AES_POLY on each doubling.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                r = r ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? AES_POLY : 8'h00);
        end
        return r;
    endfunction

    // Inverse as a^254 = a^(2+4+...+128); maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ SBOX_AFFINE_C;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        return rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// ----------------------------------------------------------------------------
// sbox_lane
//   Combinational single-byte AES S-box / inverse S-box. One GF(2^8) inverter
//   is shared by both modes; the forward affine follows it, the inverse affine
//   precedes it.
//   Ports:
//     byte_in   in   8   input byte
//     inv       in   1   0 = forward S-box, 1 = inverse S-box
//     byte_out  out  8   substituted byte
// ----------------------------------------------------------------------------
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       inv,
    output logic [7:0] byte_out
);

    sbox_mode_e w_mode;
    logic [7:0] w_pre;
    logic [7:0] w_gfinv;

    always_comb begin
        w_mode   = sbox_mode_e'(inv);
        w_pre    = (w_mode == SBOX_INV) ? affine_inv(byte_in) : byte_in;
        w_gfinv  = gf_inv(w_pre);
        byte_out = (w_mode == SBOX_INV) ? w_gfinv : affine_fwd(w_gfinv);
    end

endmodule

// File: rtl/sbox_array_pipe.sv
// ----------------------------------------------------------------------------
// sbox_array_pipe
//   LANES-wide, two-stage pipelined AES SubBytes / InvSubBytes with valid/ready
//   flow control and a sideband tag. 1 transaction/cycle, 2-cycle latency.
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     flush               synchronous clear of in-flight transactions
//     in_valid/in_ready   input handshake
//     in_data/in_inv      bytes (lane i = bits 8i+7:8i) and mode per transaction
//     in_tag              sideband tag, returned unchanged
//     out_valid/out_ready output handshake
//     out_data/out_tag    substituted bytes and tag
//     busy                any stage occupied
// ----------------------------------------------------------------------------
module sbox_array_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    logic                r_v1;
    logic [8*LANES-1:0]  r_data1;
    logic                r_inv1;
    logic [TAG_W-1:0]    r_tag1;
    logic                r_v2;
    logic [8*LANES-1:0]  r_data2;
    logic [TAG_W-1:0]    r_tag2;

    logic                w_rdy1;
    logic                w_rdy2;
    logic                w_accept;
    logic [8*LANES-1:0]  w_sub;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .byte_in  (r_data1[8*g +: 8]),
            .inv      (r_inv1),
            .byte_out (w_sub[8*g +: 8])
        );
    end

    // out_ready reaches in_ready combinationally; there is no skid buffer.
    always_comb begin
        w_rdy2   = !r_v2 || out_ready;
        w_rdy1   = !r_v1 || w_rdy2;
        in_ready = w_rdy1 && !flush && !rst;
        w_accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_data1 <= '0;
            r_inv1  <= 1'b0;
            r_tag1  <= '0;
            r_v2    <= 1'b0;
            r_data2 <= '0;
            r_tag2  <= '0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_rdy2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_data2 <= w_sub;
                    r_tag2  <= r_tag1;
                end
            end
            if (w_rdy1) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_data1 <= in_data;
                    r_inv1  <= in_inv;
                    r_tag1  <= in_tag;
                end
            end
        end
    end

    always_comb begin
        out_valid = r_v2;
        out_data  = r_data2;
        out_tag   = r_tag2;
        busy      = r_v1 || r_v2;
    end

endmodule

// File: tb/tb_sbox_array_pipe.sv
module tb_sbox_array_pipe;

    localparam int LANES = 4;
    localparam int TAG_W = 4;
    localparam int DW    = 8 * LANES;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    sbox_array_pipe #(
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference S-box tables built from FIPS-197 definitions by brute force.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
                     ^ a[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
            fwd_tab[x] = b;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++)
            r[8*l +: 8] = inv ? inv_tab[d[8*l +: 8]] : fwd_tab[d[8*l +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction with exact latency check: accept at edge k, valid after k+2.
    task automatic send_one(input string name, input logic [DW-1:0] d, input logic inv,
                            input logic [TAG_W-1:0] tag, input logic [DW-1:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = inv;
        in_tag    = tag;
        #1;
        chk({name, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk({name, " valid@k+1"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, " valid@k+2"}, 64'(out_valid), 64'd1);
        chk({name, " data"}, 64'(out_data), 64'(exp));
        chk({name, " tag"}, 64'(out_tag), 64'(tag));
        tick();
    endtask

    logic [DW-1:0]    st_d   [64];
    logic [DW-1:0]    st_exp [64];
    logic [DW-1:0]    res    [64];
    logic             st_inv [64];
    logic [TAG_W-1:0] st_tag [64];

    task automatic run_stream(input string name, input int n, input bit rnd, output int cycles);
        int  idx_in;
        int  idx_out;
        bit  acc;
        bit  drn;
        bit  stall;
        logic [DW-1:0]    hd;
        logic [TAG_W-1:0] ht;
        idx_in  = 0;
        idx_out = 0;
        cycles  = 0;
        while (idx_out < n && cycles < 2000) begin
            in_valid  = (idx_in < n);
            in_data   = st_d[idx_in < n ? idx_in : 0];
            in_inv    = st_inv[idx_in < n ? idx_in : 0];
            in_tag    = st_tag[idx_in < n ? idx_in : 0];
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            acc   = in_valid && in_ready;
            drn   = out_valid && out_ready;
            stall = out_valid && !out_ready;
            hd    = out_data;
            ht    = out_tag;
            tick();
            cycles++;
            if (acc) idx_in++;
            if (drn) begin
                chk($sformatf("%s data[%0d]", name, idx_out), 64'(hd), 64'(st_exp[idx_out]));
                chk($sformatf("%s tag[%0d]", name, idx_out), 64'(ht), 64'(st_tag[idx_out]));
                res[idx_out] = hd;
                idx_out++;
            end
            if (stall) begin
                chk({name, " stall hold"}, {31'd0, out_valid, out_tag, hd == out_data ? 28'd0 : 28'd1},
                    {31'd0, 1'b1, ht, 28'd0});
            end
        end
        in_valid = 1'b0;
        chk({name, " count"}, 64'(idx_out), 64'(n));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          inv;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   cyc;

    initial begin
        vecs[0] = '{data: 32'hE99AA019, inv: 1'b0, exp: 32'h1EB8E0D4};
        vecs[1] = '{data: 32'hFF530100, inv: 1'b0, exp: 32'h16ED7C63};
        vecs[2] = '{data: 32'h16ED7C63, inv: 1'b1, exp: 32'hFF530100};
        vecs[3] = '{data: 32'h63636363, inv: 1'b1, exp: 32'h00000000};
        vecs[4] = '{data: 32'h1EB8E0D4, inv: 1'b1, exp: 32'hE99AA019};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_inv    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        build_tables();

        // Reference-table self-consistency with known FIPS-197 points.
        chk("ref S(53)", 64'(fwd_tab[8'h53]), 64'hED);
        chk("ref Inv(16)", 64'(inv_tab[8'h16]), 64'hFF);

        #3;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_tag", 64'(out_tag), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            send_one($sformatf("vec%0d", i), vecs[i].data, vecs[i].inv, 4'(i + 3), vecs[i].exp);

        // Exhaustive: all 256 bytes forward, then back through inverse.
        for (int i = 0; i < 64; i++) begin
            st_d[i]   = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            st_inv[i] = 1'b0;
            st_tag[i] = 4'(i);
            st_exp[i] = model(st_d[i], 1'b0);
        end
        run_stream("exh fwd", 64, 1'b0, cyc);
        chk("exh fwd cycles", 64'(cyc), 64'd66);
        for (int i = 0; i < 64; i++) begin
            st_exp[i] = st_d[i];
            st_d[i]   = res[i];
            st_inv[i] = 1'b1;
        end
        run_stream("exh inv", 64, 1'b0, cyc);

        // Random tagged stream with random backpressure.
        for (int i = 0; i < 20; i++) begin
            st_d[i]   = $urandom;
            st_inv[i] = 1'($urandom_range(0, 1));
            st_tag[i] = 4'($urandom_range(0, 15));
            st_exp[i] = model(st_d[i], st_inv[i]);
        end
        run_stream("rand", 20, 1'b1, cyc);

        // Alternating modes each cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            st_d[i]   = (i % 2 == 0) ? 32'h00000000 : 32'h63636363;
            st_inv[i] = 1'(i % 2);
            st_tag[i] = 4'(i);
            st_exp[i] = (i % 2 == 0) ? 32'h63636363 : 32'h00000000;
        end
        run_stream("alt", 8, 1'b0, cyc);
        chk("alt cycles", 64'(cyc), 64'd10);

        // Fill pipe under backpressure, then flush with input offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h01020304;
        in_inv    = 1'b0;
        in_tag    = 4'h9;
        tick();
        tick();
        chk("full out_valid", 64'(out_valid), 64'd1);
        chk("full in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        #1;
        chk("flush in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush busy", 64'(busy), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush no accept", 64'(busy), 64'd0);

        // Async reset mid-stream.
        in_valid = 1'b1;
        in_data  = 32'hAABBCCDD;
        in_tag   = 4'h5;
        tick();
        tick();
        chk("pre-rst out_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst out_data", 64'(out_data), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        send_one("post-rst", 32'hE99AA019, 1'b0, 4'hC, 32'h1EB8E0D4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
